// File: rtl/soc_system_pwm_ctrl.sv
// Four-channel PWM controller with an Avalon-MM register slave.
//
// Register map (word address):
//   0 CTRL     [0] EN, [1] IRQ_EN, [2] INV
//   1 PRESCALE [15:0]
//   2 PERIOD   [7:0]
//   3 STATUS   [0] WRAP (write 1 to clear)
//   4-7 DUTY0-DUTY3 [7:0]
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM write side
//   readdata              zero-wait-state read data, combinational from address
//   pwm_out[3:0]          registered PWM outputs
//   irq                   level interrupt, WRAP & IRQ_EN
module soc_system_pwm_ctrl #(
  parameter logic [7:0]  RESET_PERIOD   = 8'd255,
  parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  pwm_out,
  output logic        irq
);

  // Programmer-visible registers
  logic [2:0]       ctrl_q, ctrl_d;
  logic [15:0]      prescale_q, prescale_d;
  logic [7:0]       period_q, period_d;
  logic [3:0][7:0]  duty_q, duty_d;
  logic             wrap_q, wrap_d;

  // Counting engine and shadow copies
  logic [15:0]      pcnt_q, pcnt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       period_act_q, period_act_d;
  logic [3:0][7:0]  duty_act_q, duty_act_d;
  logic             en_prev_q;
  logic [3:0]       pwm_q, pwm_d;

  logic wr_en;
  logic en, inv, run, start, tick, wrap_evt, load;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  assign wr_en = chipselect & ~write_n;
  assign en    = ctrl_q[0];
  assign inv   = ctrl_q[2];
  // First cycle with EN set only loads shadows; counting starts the cycle after.
  assign start = en & ~en_prev_q;
  assign run   = en & en_prev_q;
  assign tick     = run && (pcnt_q == prescale_q);
  assign wrap_evt = tick && (cnt_q == period_act_q);
  assign load     = wrap_evt | start;

  // Register writes
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    period_d   = period_q;
    duty_d     = duty_q;
    if (wr_en) begin
      case (address)
        3'd0:    ctrl_d     = writedata[2:0];
        3'd1:    prescale_d = writedata[15:0];
        3'd2:    period_d   = writedata[7:0];
        3'd4, 3'd5, 3'd6, 3'd7: duty_d[address[1:0]] = writedata[7:0];
        default: ;
      endcase
    end
  end

  // WRAP: a wrap in the same cycle as a clear wins.
  always_comb begin
    wrap_d = wrap_q;
    if (wr_en && (address == 3'd3) && writedata[0]) begin
      wrap_d = 1'b0;
    end
    if (wrap_evt) begin
      wrap_d = 1'b1;
    end
  end

  // Counters; pcnt past a shrunken PRESCALE rolls over through 16-bit wrap.
  always_comb begin
    pcnt_d = 16'd0;
    cnt_d  = 8'd0;
    if (run) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      if (wrap_evt) begin
        cnt_d = 8'd0;
      end else if (tick) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Shadows only change at a wrap or on enable, so a period never glitches.
  always_comb begin
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    if (load) begin
      period_act_d = period_q;
      duty_act_d   = duty_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pwm_d[i] = run ? ((cnt_q < duty_act_q[i]) ^ inv) : inv;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q       <= 3'd0;
      prescale_q   <= RESET_PRESCALE;
      period_q     <= RESET_PERIOD;
      duty_q       <= '0;
      wrap_q       <= 1'b0;
      pcnt_q       <= 16'd0;
      cnt_q        <= 8'd0;
      period_act_q <= RESET_PERIOD;
      duty_act_q   <= '0;
      en_prev_q    <= 1'b0;
      pwm_q        <= 4'd0;
    end else begin
      ctrl_q       <= ctrl_d;
      prescale_q   <= prescale_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      wrap_q       <= wrap_d;
      pcnt_q       <= pcnt_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      en_prev_q    <= en;
      pwm_q        <= pwm_d;
    end
  end

  always_comb begin
    case (address)
      3'd0:    readdata = {29'd0, ctrl_q};
      3'd1:    readdata = {16'd0, prescale_q};
      3'd2:    readdata = {24'd0, period_q};
      3'd3:    readdata = {31'd0, wrap_q};
      default: readdata = {24'd0, duty_q[address[1:0]]};
    endcase
  end

  assign pwm_out = pwm_q;
  assign irq     = wrap_q & ctrl_q[1];

endmodule
